// File: rtl/sa_input_loader_pkg.sv
// Shared definitions for the systolic-adapter input loader.
// Holds default frame geometry, the frame length constant, the loader
// state encoding and a small index-width helper.
package sa_input_loader_pkg;

  localparam int unsigned WORD_W_DEF        = 10;
  localparam int unsigned FMAP_SIZE_SA_DEF  = 576;
  localparam int unsigned FMAP_CHANNELS_DEF = 6;

  // Words per frame: weights, one bias, feature map, upstream error.
  localparam int unsigned FRAME_LEN_N = FMAP_CHANNELS_DEF + 1 + 2 * FMAP_SIZE_SA_DEF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_LOAD_B = 3'd2,
    S_LOAD_F = 3'd3,
    S_LOAD_E = 3'd4,
    S_START  = 3'd5,
    S_WAIT   = 3'd6,
    S_DONE   = 3'd7
  } state_e;

  // Bits needed to index a table of 'depth' entries (never less than 1).
  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sa_input_loader.sv
// Frame loader in front of the systolic adapter stage.
// Accepts a valid/ready word stream (weights, bias, fmap, error), stores
// each word into flat output registers, fires do_fp once a well-formed
// frame is complete, then waits for done_BP and pulses frame_done.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     upstream handshake; in_data word, in_last frame end
//   weights_SA, biases_SA loaded adapter weights and bias
//   fp_fmap, error_IN     loaded feature map and upstream error
//   do_fp                 one-cycle start pulse to the adapter stage
//   done_BP               adapter finished backprop (honoured in S_WAIT only)
//   busy                  high outside S_IDLE
//   frame_done            one-cycle pulse after done_BP accepted
//   frame_err             sticky framing-error flag, cleared by next frame start
module sa_input_loader
  import sa_input_loader_pkg::*;
#(
  parameter int unsigned FMAP_SIZE_SA  = FMAP_SIZE_SA_DEF,
  parameter int unsigned FMAP_CHANNELS = FMAP_CHANNELS_DEF,
  parameter int unsigned WORD_W        = WORD_W_DEF
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [WORD_W-1:0]                         in_data,
  input  logic                                      in_last,
  output logic [FMAP_CHANNELS-1:0][WORD_W-1:0]      weights_SA,
  output logic [WORD_W-1:0]                         biases_SA,
  output logic [FMAP_SIZE_SA-1:0][WORD_W-1:0]       fp_fmap,
  output logic [FMAP_SIZE_SA-1:0][WORD_W-1:0]       error_IN,
  output logic                                      do_fp,
  input  logic                                      done_BP,
  output logic                                      busy,
  output logic                                      frame_done,
  output logic                                      frame_err
);

  localparam int unsigned W_IDX_W = idx_width(FMAP_CHANNELS);
  localparam int unsigned F_IDX_W = idx_width(FMAP_SIZE_SA);
  localparam int unsigned IDX_W   = (W_IDX_W > F_IDX_W) ? W_IDX_W : F_IDX_W;

  localparam logic [IDX_W-1:0] W_LAST = IDX_W'(FMAP_CHANNELS - 1);
  localparam logic [IDX_W-1:0] F_LAST = IDX_W'(FMAP_SIZE_SA - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              err_q, err_d;

  logic [FMAP_CHANNELS-1:0][WORD_W-1:0] weights_q;
  logic [WORD_W-1:0]                    bias_q;
  logic [FMAP_SIZE_SA-1:0][WORD_W-1:0]  fmap_q;
  logic [FMAP_SIZE_SA-1:0][WORD_W-1:0]  error_q;

  logic accept;
  logic last_word;
  logic [W_IDX_W-1:0] w_idx;
  logic [F_IDX_W-1:0] f_idx;

  assign accept    = in_valid && in_ready;
  // Final word of the frame is the last slot of the error section.
  assign last_word = (state_q == S_LOAD_E) && (idx_q == F_LAST);
  assign w_idx     = idx_q[W_IDX_W-1:0];
  assign f_idx     = idx_q[F_IDX_W-1:0];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, shared section index and sticky error.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = err_q;
    if (accept) begin
      // in_last must coincide exactly with the final frame word.
      if (in_last != last_word) begin
        state_d = S_IDLE;
        idx_d   = '0;
        err_d   = 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            err_d = 1'b0;
            if (FMAP_CHANNELS > 1) begin
              state_d = S_LOAD_W;
              idx_d   = IDX_W'(1);
            end else begin
              state_d = S_LOAD_B;
              idx_d   = '0;
            end
          end
          S_LOAD_W: begin
            if (idx_q == W_LAST) begin
              state_d = S_LOAD_B;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
          S_LOAD_B: begin
            state_d = S_LOAD_F;
            idx_d   = '0;
          end
          S_LOAD_F: begin
            if (idx_q == F_LAST) begin
              state_d = S_LOAD_E;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
          S_LOAD_E: begin
            if (idx_q == F_LAST) begin
              state_d = S_START;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
          default: begin
          end
        endcase
      end
    end else begin
      case (state_q)
        S_START: state_d = S_WAIT;
        S_WAIT:  if (done_BP) state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: begin
        end
      endcase
    end
  end

  // Outputs decoded from the registered state; in_ready is held low in reset.
  always_comb begin
    in_ready   = 1'b0;
    busy       = 1'b0;
    do_fp      = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      S_IDLE:   in_ready = rst_n;
      S_LOAD_W,
      S_LOAD_B,
      S_LOAD_F,
      S_LOAD_E: begin
        in_ready = rst_n;
        busy     = 1'b1;
      end
      S_START: begin
        busy  = 1'b1;
        do_fp = 1'b1;
      end
      S_WAIT:  busy = 1'b1;
      S_DONE: begin
        busy       = 1'b1;
        frame_done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      err_q <= 1'b0;
    end else begin
      idx_q <= idx_d;
      err_q <= err_d;
    end
  end

  // Slot storage: each accepted word lands in the slot named by state and index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weights_q <= '0;
      bias_q    <= '0;
      fmap_q    <= '0;
      error_q   <= '0;
    end else if (accept) begin
      case (state_q)
        S_IDLE:   weights_q[W_IDX_W'(0)] <= in_data;
        S_LOAD_W: weights_q[w_idx]       <= in_data;
        S_LOAD_B: bias_q                 <= in_data;
        S_LOAD_F: fmap_q[f_idx]          <= in_data;
        S_LOAD_E: error_q[f_idx]         <= in_data;
        default: begin
        end
      endcase
    end
  end

  assign weights_SA = weights_q;
  assign biases_SA  = bias_q;
  assign fp_fmap    = fmap_q;
  assign error_IN   = error_q;
  assign frame_err  = err_q;

endmodule
